mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles in a grant state waiting for a memory ack; legal range 2..255.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_rd_req  in  1  fetch read request; held until if_rd_ack.
REQ-007 if_rd_addr  in  ADDR_W  fetch read address; stable while if_rd_req is high.
REQ-008 if_rd_data  out  DATA_W  fetch read data; valid only while if_rd_ack is high.
REQ-009 if_rd_ack  out  1  one-cycle completion pulse to fetch.
REQ-010 ls_req  in  1  load/store request; held until ls_ack.
REQ-011 ls_we  in  1  1 = store, 0 = load; stable while ls_req is high.
REQ-012 ls_addr  in  ADDR_W  load/store address; stable while ls_req is high.
REQ-013 ls_wr_data  in  DATA_W  store data; stable while ls_req is high.
REQ-014 ls_rd_data  out  DATA_W  load data; valid only while ls_ack is high.
REQ-015 ls_ack  out  1  one-cycle completion pulse to load/store.
REQ-016 mem_rd_addr / mem_rd_addr_valid  out  ADDR_W / 1  memory read request.
REQ-017 mem_rd_data / mem_rd_ack  in  DATA_W / 1  memory read response; ack is registered and arrives one cycle after valid.
REQ-018 mem_wr_addr / mem_wr_data / mem_wr_data_valid  out  ADDR_W / DATA_W / 1  memory write request.
REQ-019 mem_wr_ack  in  1  memory write ack; registered and arrives one cycle after valid.
REQ-020 bus_err  out  1  pulses together with if_rd_ack or ls_ack when a timeout occurs.

Function
REQ-021 The FSM shall have five states: IDLE, IF_RD, LS_RD, LS_WR and RESP, with exactly one memory transaction outstanding at a time.
REQ-022 In IDLE, at the clock edge, the FSM shall grant one sampled request.
- Grant goes to ls_req → LS_WR if ls_we, else LS_RD; otherwise to if_rd_req → IF_RD.
- The granted address and write data shall be captured into registers at the same edge.
REQ-023 In IF_RD and LS_RD, mem_rd_addr_valid shall equal NOT mem_rd_addr_valid's ack input, i.e. valid = !mem_rd_ack; mem_rd_addr shall be driven from the captured address register.
REQ-024 In LS_WR, mem_wr_data_valid shall equal !mem_wr_ack; mem_wr_addr and mem_wr_data shall be driven from the captured registers.
REQ-025 In every state other than the matching grant state, all mem_*_valid outputs shall be 0.
REQ-026 On a matching mem ack in a grant state:
- capture mem_rd_data (reads only);
- go to RESP;
- assert the granted requester's ack, with its data output, for exactly one cycle (the RESP cycle).
REQ-027 RESP shall always return to IDLE after one cycle.
REQ-028 Latency from request first high to ack pulse shall be 3 cycles, and back-to-back grants shall occur every 4 cycles.
REQ-029 A requester that keeps its req high in the cycle after its ack shall be treated as issuing a new request.
REQ-030 A 8-bit wait counter shall clear on entry to each grant state and increment every cycle the state waits without an ack.
REQ-031 When the wait counter reaches TIMEOUT-1 without an ack:
- go to RESP;
- pulse the granted requester's ack with bus_err=1 and data=0;
- drop mem valid.
REQ-032 A mem ack arriving while in IDLE or RESP (a stale ack) shall be ignored.
REQ-033 A mem ack arriving in a non-matching grant state (rd ack during LS_WR, or wr ack during a read state) shall be ignored.
REQ-034 ls_rd_data shall hold 0 when a store completes.

Reset
REQ-035 While reset is high the block shall:
- enter IDLE;
- hold all outputs at 0 (acks, valids, bus_err, data and address outputs);
- clear the wait counter and the captured registers;
- set last_grant to IF.
REQ-036 A reset during a grant state shall abort the transaction with no requester ack; any later stale mem ack is ignored per REQ-032.

Configuration
REQ-037 With macro MEM_ARB_RR_EN defined, simultaneous requests in IDLE shall go to the requester not recorded in last_grant.
- last_grant shall update on every grant.
- The first tie after reset goes to LS.
REQ-038 Without MEM_ARB_RR_EN, arbitration shall be fixed priority with LS over IF, and no last_grant register shall exist.

Verification
REQ-039 Memory word 0 is preloaded with 32'h00100133. if_rd_req=1 with if_rd_addr=0 shall give if_rd_ack=1 with if_rd_data=32'h00100133 three cycles later; ls_ack shall stay 0.
REQ-040 ls_req=1 with ls_we=1, ls_addr=3 and ls_wr_data=32'h2F, followed by ls_req with ls_we=0 and ls_addr=3, shall give ls_ack with ls_rd_data=32'h2F on the second ack.
REQ-041 With if_rd_req and ls_req both held high for 16 cycles:
- without MEM_ARB_RR_EN, 4 ls_ack pulses and 0 if_rd_ack pulses;
- with MEM_ARB_RR_EN, ack pulses alternate LS, IF, LS, IF.
REQ-042 With the memory ack tied to 0 and TIMEOUT=16, a fetch request shall give if_rd_ack=1, bus_err=1 and if_rd_data=0 exactly once, and the FSM shall then return to IDLE.
REQ-043 A reset pulse one cycle after an LS_RD grant shall produce no ls_ack and hold all valids at 0; a following fetch to address 0 shall complete normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around mem_arbiter.
// master: requesters plus memory model side; slave: the arbiter itself.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_rd_req;
    logic [ADDR_W-1:0] if_rd_addr;
    logic [DATA_W-1:0] if_rd_data;
    logic              if_rd_ack;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wr_data;
    logic [DATA_W-1:0] ls_rd_data;
    logic              ls_ack;

    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_addr_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_ack;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_data_valid;
    logic              mem_wr_ack;

    logic              bus_err;

    modport master (
        output if_rd_req, if_rd_addr, ls_req, ls_we, ls_addr, ls_wr_data,
               mem_rd_data, mem_rd_ack, mem_wr_ack,
        input  if_rd_data, if_rd_ack, ls_rd_data, ls_ack, mem_rd_addr, mem_rd_addr_valid,
               mem_wr_addr, mem_wr_data, mem_wr_data_valid, bus_err
    );

    modport slave (
        input  if_rd_req, if_rd_addr, ls_req, ls_we, ls_addr, ls_wr_data,
               mem_rd_data, mem_rd_ack, mem_wr_ack,
        output if_rd_data, if_rd_ack, ls_rd_data, ls_ack, mem_rd_addr, mem_rd_addr_valid,
               mem_wr_addr, mem_wr_data, mem_wr_data_valid, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed LS-over-IF priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StIfRd, StLsRd, StLsWr, StResp} state_e;

    localparam logic [7:0] WaitMax = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic [7:0]        wait_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              if_ack_q;
    logic              ls_ack_q;
    logic              err_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] ls_data_q;
    logic              grant_ls;
    logic              ack_hit;

`ifdef MEM_ARB_RR_EN
    logic last_ls_q;

    // On a tie, grant whoever did not win last time.
    always_comb begin
        grant_ls = bus.ls_req;
        if (bus.ls_req && bus.if_rd_req) grant_ls = !last_ls_q;
    end
`else
    assign grant_ls = bus.ls_req;
`endif

    // Only the ack matching the current grant state counts; stray acks are ignored.
    assign ack_hit = ((state_q == StIfRd || state_q == StLsRd) && bus.mem_rd_ack) ||
                     (state_q == StLsWr && bus.mem_wr_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_ack_q  <= 1'b0;
            ls_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls_q <= 1'b0;
`endif
        end else begin
            if_ack_q  <= 1'b0;
            ls_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.ls_req || bus.if_rd_req) begin
                        wait_q <= '0;
`ifdef MEM_ARB_RR_EN
                        last_ls_q <= grant_ls;
`endif
                        if (grant_ls) begin
                            addr_q  <= bus.ls_addr;
                            wdata_q <= bus.ls_wr_data;
                            state_q <= bus.ls_we ? StLsWr : StLsRd;
                        end else begin
                            addr_q  <= bus.if_rd_addr;
                            state_q <= StIfRd;
                        end
                    end
                end
                StIfRd, StLsRd, StLsWr: begin
                    if (ack_hit || wait_q == WaitMax) begin
                        // Timeout completes the request with bus_err and zero data.
                        state_q <= StResp;
                        err_q   <= !ack_hit;
                        if (state_q == StIfRd) begin
                            if_ack_q <= 1'b1;
                            if (ack_hit) if_data_q <= bus.mem_rd_data;
                        end else begin
                            ls_ack_q <= 1'b1;
                            if (ack_hit && state_q == StLsRd) ls_data_q <= bus.mem_rd_data;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.if_rd_ack         = if_ack_q;
    assign bus.if_rd_data        = if_data_q;
    assign bus.ls_ack            = ls_ack_q;
    assign bus.ls_rd_data        = ls_data_q;
    assign bus.bus_err           = err_q;
    assign bus.mem_rd_addr       = addr_q;
    assign bus.mem_wr_addr       = addr_q;
    assign bus.mem_wr_data       = wdata_q;
    assign bus.mem_rd_addr_valid = (state_q == StIfRd || state_q == StLsRd) && !bus.mem_rd_ack;
    assign bus.mem_wr_data_valid = (state_q == StLsWr) && !bus.mem_wr_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 16-word registered-ack memory model.
// Expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    logic mem_en;
    logic [31:0] mem [16];

    int n_asserts = 0;
    int n_fail    = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack and data registered one cycle after valid; mem_en=0 never acks.
    always @(posedge clk) begin
        if (reset) begin
            bus.mem_rd_ack  <= 1'b0;
            bus.mem_wr_ack  <= 1'b0;
            bus.mem_rd_data <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 32'h00100133;
        end else begin
            bus.mem_rd_ack  <= bus.mem_rd_addr_valid && mem_en;
            bus.mem_rd_data <= (bus.mem_rd_addr_valid && mem_en) ?
                               mem[bus.mem_rd_addr[3:0]] : 32'h0;
            bus.mem_wr_ack  <= bus.mem_wr_data_valid && mem_en;
            if (bus.mem_wr_data_valid && mem_en) mem[bus.mem_wr_addr[3:0]] <= bus.mem_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          n_ls, n_if, idx, ack_cyc, pulses;
    logic [3:0]  order;
    logic        err_seen;
    logic [31:0] data_seen;

    initial begin
        reset          = 1'b1;
        mem_en         = 1'b1;
        bus.if_rd_req  = 1'b0;
        bus.if_rd_addr = '0;
        bus.ls_req     = 1'b0;
        bus.ls_we      = 1'b0;
        bus.ls_addr    = '0;
        bus.ls_wr_data = '0;
        repeat (2) @(negedge clk);

        chk("rst_if_ack",   32'(bus.if_rd_ack), 32'd0);
        chk("rst_ls_ack",   32'(bus.ls_ack), 32'd0);
        chk("rst_bus_err",  32'(bus.bus_err), 32'd0);
        chk("rst_rd_valid", 32'(bus.mem_rd_addr_valid), 32'd0);
        chk("rst_wr_valid", 32'(bus.mem_wr_data_valid), 32'd0);
        chk("rst_rd_addr",  bus.mem_rd_addr, 32'd0);
        chk("rst_wr_data",  bus.mem_wr_data, 32'd0);
        chk("rst_if_data",  bus.if_rd_data, 32'd0);
        chk("rst_ls_data",  bus.ls_rd_data, 32'd0);
        reset = 1'b0;

        // Fetch of word 0: ack three cycles after request
        @(negedge clk);
        bus.if_rd_req  = 1'b1;
        bus.if_rd_addr = 32'd0;
        @(negedge clk);
        chk("fetch_c1_valid", 32'(bus.mem_rd_addr_valid), 32'd1);
        chk("fetch_c1_ack",   32'(bus.if_rd_ack), 32'd0);
        @(negedge clk);
        chk("fetch_c2_valid", 32'(bus.mem_rd_addr_valid), 32'd0);
        chk("fetch_c2_ack",   32'(bus.if_rd_ack), 32'd0);
        @(negedge clk);
        chk("fetch_ack",    32'(bus.if_rd_ack), 32'd1);
        chk("fetch_data",   bus.if_rd_data, 32'h00100133);
        chk("fetch_ls_ack", 32'(bus.ls_ack), 32'd0);
        chk("fetch_err",    32'(bus.bus_err), 32'd0);
        bus.if_rd_req = 1'b0;
        @(negedge clk);
        chk("fetch_ack_drop", 32'(bus.if_rd_ack), 32'd0);
        chk("fetch_data_drop", bus.if_rd_data, 32'd0);

        // Store 0x2F to address 3, then load it back
        bus.ls_req     = 1'b1;
        bus.ls_we      = 1'b1;
        bus.ls_addr    = 32'd3;
        bus.ls_wr_data = 32'h2F;
        @(negedge clk);
        chk("st_wr_valid", 32'(bus.mem_wr_data_valid), 32'd1);
        chk("st_wr_addr",  bus.mem_wr_addr, 32'd3);
        chk("st_wr_data",  bus.mem_wr_data, 32'h2F);
        chk("st_rd_valid", 32'(bus.mem_rd_addr_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("st_ack",     32'(bus.ls_ack), 32'd1);
        chk("st_rd_data", bus.ls_rd_data, 32'd0);
        chk("st_if_ack",  32'(bus.if_rd_ack), 32'd0);
        bus.ls_req = 1'b0;
        @(negedge clk);
        bus.ls_req = 1'b1;
        bus.ls_we  = 1'b0;
        repeat (3) @(negedge clk);
        chk("ld_ack",  32'(bus.ls_ack), 32'd1);
        chk("ld_data", bus.ls_rd_data, 32'h2F);
        bus.ls_req = 1'b0;
        @(negedge clk);

        // Both requesters held for 16 cycles after a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.if_rd_req = 1'b1;
        bus.ls_req    = 1'b1;
        bus.ls_we     = 1'b0;
        n_ls = 0; n_if = 0; idx = 0; order = 4'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus.ls_ack) begin
                n_ls++;
                if (idx < 4) order[idx] = 1'b1;
                idx++;
            end
            if (bus.if_rd_ack) begin
                n_if++;
                if (idx < 4) order[idx] = 1'b0;
                idx++;
            end
        end
        bus.if_rd_req = 1'b0;
        bus.ls_req    = 1'b0;
`ifdef MEM_ARB_RR_EN
        chk("tie_ls_pulses", 32'(n_ls), 32'd2);
        chk("tie_if_pulses", 32'(n_if), 32'd2);
        chk("tie_order",     32'(order), 32'h5);
`else
        chk("tie_ls_pulses", 32'(n_ls), 32'd4);
        chk("tie_if_pulses", 32'(n_if), 32'd0);
        chk("tie_order",     32'(order), 32'hF);
`endif
        repeat (3) @(negedge clk);

        // Memory never acks: fetch times out after TIMEOUT wait cycles
        mem_en = 1'b0;
        bus.if_rd_req  = 1'b1;
        bus.if_rd_addr = 32'd0;
        pulses = 0; ack_cyc = 0; err_seen = 1'b0; data_seen = 32'hFFFF_FFFF;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 5)  chk("to_wait_valid", 32'(bus.mem_rd_addr_valid), 32'd1);
            if (i == 18) chk("to_after_valid", 32'(bus.mem_rd_addr_valid), 32'd0);
            if (bus.if_rd_ack) begin
                pulses++;
                ack_cyc   = i;
                err_seen  = bus.bus_err;
                data_seen = bus.if_rd_data;
                bus.if_rd_req = 1'b0;
            end
        end
        chk("to_pulses",  32'(pulses), 32'd1);
        chk("to_latency", 32'(ack_cyc), 32'd17);
        chk("to_bus_err", 32'(err_seen), 32'd1);
        chk("to_data",    data_seen, 32'd0);
        mem_en = 1'b1;

        // Reset one cycle into an LS_RD grant; the late memory ack must be ignored
        @(negedge clk);
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 32'd3;
        @(negedge clk);
        chk("abort_rd_valid", 32'(bus.mem_rd_addr_valid), 32'd1);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.ls_req = 1'b0;
        @(negedge clk);
        chk("abort_rst_rd_valid", 32'(bus.mem_rd_addr_valid), 32'd0);
        chk("abort_rst_wr_valid", 32'(bus.mem_wr_data_valid), 32'd0);
        chk("abort_rst_ls_ack",   32'(bus.ls_ack), 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ls_ack || bus.if_rd_ack || bus.mem_rd_addr_valid) pulses++;
        end
        chk("abort_quiet", 32'(pulses), 32'd0);
        bus.if_rd_req  = 1'b1;
        bus.if_rd_addr = 32'd0;
        repeat (3) @(negedge clk);
        chk("post_abort_ack",  32'(bus.if_rd_ack), 32'd1);
        chk("post_abort_data", bus.if_rd_data, 32'h00100133);
        chk("post_abort_err",  32'(bus.bus_err), 32'd0);
        bus.if_rd_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
